// File: rtl/sdram_line_fetcher.sv
// Burst read master for the DDR local interface with credit-limited
// outstanding reads feeding a first-word-fall-through pixel FIFO.
module sdram_line_fetcher #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [15:0]           word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  local_init_done,
    input  logic                  local_ready,
    output logic                  local_read_req,
    output logic                  local_write_req,
    output logic                  local_burstbegin,
    output logic [ADDR_W-1:0]     local_address,
    output logic [2:0]            local_size,
    output logic [DATA_W/8-1:0]   local_be,
    input  logic [DATA_W-1:0]     local_rdata,
    input  logic                  local_rdata_valid,
    output logic [DATA_W-1:0]     pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       rem_q, rem_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wp_q, rp_q;
    logic              pres_q, pres_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic [2:0]        len;
    logic [CW+1:0]     need;
    logic              req, accept, push, pop;

    always_comb begin
        if (rem_q < 16'(MAX_BURST)) len = rem_q[2:0];
        else                        len = 3'(MAX_BURST);
    end

    // Reserve FIFO room for every word already in flight plus this burst.
    assign need   = (CW+2)'(cnt_q) + (CW+2)'(out_q) + (CW+2)'(len);
    assign req    = (state_q == S_ISSUE) && (need <= (CW+2)'(FIFO_DEPTH));
    assign accept = req && local_ready;
    assign push   = local_rdata_valid && (out_q != '0);
    assign pop    = pix_ready && (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = err_q | (local_rdata_valid && (out_q == '0));
        pres_d  = req && !local_ready;
        out_d   = out_q + (accept ? CW'(len) : '0) - (push ? CW'(1) : '0);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_count == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = start_addr;
                        rem_d   = word_count;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (local_init_done) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    addr_d = addr_q + ADDR_W'(len);
                    rem_d  = rem_q - 16'(len);
                    if (rem_q == 16'(len)) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (out_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            pres_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            pres_q  <= pres_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= local_rdata;
    end

    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign err              = err_q;
    assign local_read_req   = req;
    assign local_write_req  = 1'b0;
    assign local_burstbegin = req && !pres_q;
    assign local_address    = addr_q;
    assign local_size       = len;
    assign local_be         = '1;
    assign pix_valid        = (cnt_q != '0);
    assign pix_data         = pix_valid ? mem_q[rp_q] : '0;

endmodule
